// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one datapath instruction port among NUM_REQ requesters.
// Each requester gets a private start/finished handshake and a private result register.
module dp_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned INSTR_W  = 64,
    parameter int unsigned RESULT_W = 16,
    parameter int unsigned GRANT_W  = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NUM_REQ-1:0]          i_req_start,
    input  logic [NUM_REQ*INSTR_W-1:0]  i_req_instr,
    output logic [NUM_REQ-1:0]          o_req_finished,
    output logic [NUM_REQ*RESULT_W-1:0] o_req_result,
    output logic                        o_dp_start,
    output logic [INSTR_W-1:0]          o_dp_instr,
    input  logic                        i_dp_finished,
    input  logic [RESULT_W-1:0]         i_dp_result,
    output logic                        o_busy,
    output logic [GRANT_W-1:0]          o_grant
);

    typedef enum logic [1:0] {StIdle, StIssue, StHold, StWait} state_e;

    state_e                      r_state;
    logic [NUM_REQ-1:0]          r_pending;
    logic [NUM_REQ-1:0]          r_req_finished;
    logic [NUM_REQ*RESULT_W-1:0] r_req_result;
    logic [INSTR_W-1:0]          r_buf [NUM_REQ];
    logic                        r_dp_start;
    logic [INSTR_W-1:0]          r_dp_instr;
    logic                        r_busy;
    logic [GRANT_W-1:0]          r_grant;
    logic [GRANT_W-1:0]          r_rr_ptr;

    logic                        w_any;
    logic [GRANT_W-1:0]          w_sel;
    logic [INSTR_W-1:0]          w_sel_instr;
    logic [GRANT_W-1:0]          w_next_ptr;

    // Upward search from r_rr_ptr first; if nothing there, the lowest pending index is the wrap.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_any && r_pending[i] && (i >= int'(r_rr_ptr))) begin
                w_any = 1'b1;
                w_sel = GRANT_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_any && r_pending[i]) begin
                w_any = 1'b1;
                w_sel = GRANT_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_instr = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (GRANT_W'(i) == w_sel) begin
                w_sel_instr = r_buf[i];
            end
        end
    end

    assign w_next_ptr = (r_grant == GRANT_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_pending      <= '0;
            r_req_finished <= '1;
            r_req_result   <= '0;
            r_dp_start     <= 1'b0;
            r_dp_instr     <= '0;
            r_busy         <= 1'b0;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            // A start is only accepted while the requester is idle; otherwise it is dropped.
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (i_req_start[i] && r_req_finished[i]) begin
                    r_pending[i]      <= 1'b1;
                    r_buf[i]          <= i_req_instr[i*INSTR_W +: INSTR_W];
                    r_req_finished[i] <= 1'b0;
                end
            end

            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_grant    <= w_sel;
                        r_dp_instr <= w_sel_instr;
                        r_dp_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StIssue;
                    end
                end
                StIssue: r_state <= StHold;
                StHold: begin
                    r_dp_start <= 1'b0;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (i_dp_finished) begin
                        for (int i = 0; i < int'(NUM_REQ); i++) begin
                            if (GRANT_W'(i) == r_grant) begin
                                r_req_result[i*RESULT_W +: RESULT_W] <= i_dp_result;
                                r_req_finished[i]                    <= 1'b1;
                                r_pending[i]                         <= 1'b0;
                            end
                        end
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_finished = r_req_finished;
    assign o_req_result   = r_req_result;
    assign o_dp_start     = r_dp_start;
    assign o_dp_instr     = r_dp_instr;
    assign o_busy         = r_busy;
    assign o_grant        = r_grant;

endmodule
